// File: rtl/booth4_mult_seq.sv
// booth4_mult_seq
//   Sequential radix-4 (modified Booth) multiplier for the multdiv unit.
//   It takes WIDTH-bit operands and produces the full 2*WIDTH product by
//   retiring two multiplier bits per clock. It sits beside the divider,
//   and the multdiv wrapper muxes the results and RDY of the two.
//
// Optional feature (compile-time macro MULT_UNSIGNED_EN):
//   If MULT_UNSIGNED_EN is defined, the is_unsigned input is added. When it
//   is 1 on the start edge, both operands are zero-extended and one extra
//   iteration is run. Without the macro the engine is always signed.
//
// Ports:
//   clock           in   1      single clock, rising edge
//   reset           in   1      asynchronous active-high reset, clears all state
//   ctrl_MULT       in   1      start pulse; operands sampled on this edge
//   data_operandA   in   WIDTH  multiplicand (mc)
//   data_operandB   in   WIDTH  multiplier (mp)
//   is_unsigned     in   1      (MULT_UNSIGNED_EN only) unsigned operation select
//   data_result     out  WIDTH  low half of product
//   data_result_hi  out  WIDTH  high half of product
//   data_exception  out  1      product does not fit in WIDTH bits
//   data_resultRDY  out  1      one-cycle pulse, result/exception valid
//   busy            out  1      high while iterating
//
// A restart (ctrl_MULT) in any state aborts the current operation.
// No RDY is issued for an aborted operation.

module booth4_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
`ifdef MULT_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_result_hi,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  // The accumulator is WIDTH+2 bits wide. This lets -2*MIN_INT and
  // 2*(unsigned max) be represented. The multiplier field is also WIDTH+2
  // bits wide, so an unsigned operand can be zero-extended and consumed by
  // the extra iteration.
  localparam int EW = WIDTH + 2;
  localparam int PW = 2 * EW + 1;
  localparam logic [CNT_W-1:0] ITER_S = CNT_W'(WIDTH / 2);
  localparam logic [CNT_W-1:0] ITER_U = CNT_W'(WIDTH / 2 + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0]      prod_q;
  logic [EW-1:0]      mc_q;
  logic [CNT_W-1:0]   counter_q;
  logic               unsigned_q;

  logic               start_unsigned;
  logic [EW-1:0]      mc_ext;
  logic [EW-1:0]      mp_ext;
  logic [EW-1:0]      addend;
  logic [EW-1:0]      acc_sum;
  logic [PW-1:0]      prod_shift;
  logic [2*WIDTH-1:0] final_prod;
  logic               final_exc;
  logic [CNT_W-1:0]   iter_limit;

`ifdef MULT_UNSIGNED_EN
  assign start_unsigned = is_unsigned;
`else
  assign start_unsigned = 1'b0;
`endif

  // Extend the operands to the working width on the start edge.
  // Signed operands are sign-extended; unsigned operands are zero-extended.
  assign mc_ext = start_unsigned ? {2'b00, data_operandA}
                                 : {{2{data_operandA[WIDTH-1]}}, data_operandA};
  assign mp_ext = start_unsigned ? {2'b00, data_operandB}
                                 : {{2{data_operandB[WIDTH-1]}}, data_operandB};

  assign iter_limit = unsigned_q ? ITER_U : ITER_S;

  // Booth digit decode.
  // The select is {P[2], P[1], helper}, and the helper bit is P[0].
  always_comb begin
    addend = '0;
    case (prod_q[2:0])
      3'b001, 3'b010: addend = mc_q;
      3'b011:         addend = {mc_q[EW-2:0], 1'b0};
      3'b100:         addend = ~{mc_q[EW-2:0], 1'b0} + 1'b1;
      3'b101, 3'b110: addend = ~mc_q + 1'b1;
      default:        addend = '0;
    endcase
  end

  // Add the digit into the upper field, then arithmetic-shift the whole
  // register right by two. The two bits that drop off are already-retired
  // multiplier bits.
  assign acc_sum    = prod_q[PW-1:EW+1] + addend;
  assign prod_shift = {{2{acc_sum[EW-1]}}, acc_sum, prod_q[EW:2]};

  // After the final iteration the product starts at bit 3 for a signed
  // operation, and at bit 1 for an unsigned one. The unsigned case ran one
  // extra shift over the same field width.
  assign final_prod = unsigned_q ? prod_q[2*WIDTH:1] : prod_q[2*WIDTH+2:3];

  // Signed overflow: the upper half plus the sign bit of the lower half are
  // not all copies of one bit. Unsigned overflow: any high-half bit is set.
  assign final_exc = unsigned_q ? (|final_prod[2*WIDTH-1:WIDTH])
                                : !((&final_prod[2*WIDTH-1:WIDTH-1]) ||
                                    (~|final_prod[2*WIDTH-1:WIDTH-1]));

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A start request wins from every state.
  // This is what makes a held ctrl_MULT restart the operation every cycle.
  always_comb begin
    state_d = state_q;
    if (ctrl_MULT) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (counter_q == iter_limit) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q == RUN);

  // Datapath.
  // A start loads the operands and clears the counter. Each RUN cycle
  // retires one Booth digit. The cycle that sees the counter at its limit
  // publishes the product; the counter still steps on that cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prod_q         <= '0;
      mc_q           <= '0;
      counter_q      <= '0;
      unsigned_q     <= 1'b0;
      data_result    <= '0;
      data_result_hi <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_MULT) begin
      mc_q       <= mc_ext;
      prod_q     <= {{EW{1'b0}}, mp_ext, 1'b0};
      counter_q  <= '0;
      unsigned_q <= start_unsigned;
    end else if (state_q == RUN) begin
      counter_q <= counter_q + 1'b1;
      if (counter_q == iter_limit) begin
        data_result    <= final_prod[WIDTH-1:0];
        data_result_hi <= final_prod[2*WIDTH-1:WIDTH];
        data_exception <= final_exc;
      end else begin
        prod_q <= prod_shift;
      end
    end
  end

endmodule

// File: tb/tb_booth4_mult_seq.sv
// tb_booth4_mult_seq
//   Self-checking bench for booth4_mult_seq at WIDTH=32.
//   Expected products come from plain 64-bit arithmetic on the operands.
//   Latency, pulse shape, abort/restart and reset behaviour are each
//   exercised by their own task.
//   When MULT_UNSIGNED_EN is defined, the unsigned mode is exercised as well.

module tb_booth4_mult_seq;

  localparam int WIDTH = 32;
  localparam int LAT_S = WIDTH / 2 + 1;
  localparam int LAT_U = WIDTH / 2 + 2;
  localparam longint S_MIN = -64'sd2147483648;
  localparam longint S_MAX = 64'sd2147483647;

  logic              clock;
  logic              reset;
  logic              ctrl_MULT;
  logic [WIDTH-1:0]  data_operandA;
  logic [WIDTH-1:0]  data_operandB;
`ifdef MULT_UNSIGNED_EN
  logic              is_unsigned;
`endif
  logic [WIDTH-1:0]  data_result;
  logic [WIDTH-1:0]  data_result_hi;
  logic              data_exception;
  logic              data_resultRDY;
  logic              busy;

  int tests_run;
  int tests_failed;

  booth4_mult_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
`ifdef MULT_UNSIGNED_EN
    .is_unsigned    (is_unsigned),
`endif
    .data_result    (data_result),
    .data_result_hi (data_result_hi),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: full-width product by ordinary arithmetic.
  task automatic model_mult(input logic [31:0] a, input logic [31:0] b,
                            input bit uns, output logic [31:0] hi,
                            output logic [31:0] lo, output logic exc);
    longint      sp;
    logic [63:0] up;
    if (uns) begin
      up  = {32'b0, a} * {32'b0, b};
      hi  = up[63:32];
      lo  = up[31:0];
      exc = (up[63:32] != 32'b0);
    end else begin
      sp  = longint'($signed(a)) * longint'($signed(b));
      hi  = sp[63:32];
      lo  = sp[31:0];
      exc = (sp < S_MIN) || (sp > S_MAX);
    end
  endtask

  // Issue a one-cycle start, scramble the operand inputs afterwards, then
  // count cycles until RDY. cycles=k means RDY was seen k cycles after the
  // start edge.
  task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b,
                                input bit uns, output int cycles, output bit seen);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
`ifdef MULT_UNSIGNED_EN
    is_unsigned = uns;
`endif
    ctrl_MULT = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
`ifdef MULT_UNSIGNED_EN
    is_unsigned = ~uns;
`endif
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < 60) begin
      @(negedge clock);
      cycles++;
      if (data_resultRDY) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ctrl_MULT = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
`ifdef MULT_UNSIGNED_EN
    is_unsigned = 1'b0;
`endif
    repeat (2) @(negedge clock);
    tests_run += 5;
    if (data_result !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_result got=%h want=0", data_result); end
    if (data_result_hi !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_hi got=%h want=0", data_result_hi); end
    if (data_exception !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_exc got=%b want=0", data_exception); end
    if (data_resultRDY !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rdy got=%b want=0", data_resultRDY); end
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_directed();
    logic [31:0] av [4] = '{32'd7, 32'h8000_0000, 32'h0001_0000, 32'hFFFF_FFFF};
    logic [31:0] bv [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h0001_0000, 32'hFFFF_FFFF};
    logic [31:0] ehi, elo;
    logic        eexc;
    int          cyc;
    bit          seen;
    for (int i = 0; i < 4; i++) begin
      model_mult(av[i], bv[i], 1'b0, ehi, elo, eexc);
      start_and_wait(av[i], bv[i], 1'b0, cyc, seen);
      tests_run += 4;
      if (!seen || cyc != LAT_S) begin tests_failed++; $display("[TB] FAIL directed_latency[%0d] got=%0d seen=%0b want=%0d", i, cyc, seen, LAT_S); end
      if (data_result !== elo) begin tests_failed++; $display("[TB] FAIL directed_lo[%0d] got=%h want=%h", i, data_result, elo); end
      if (data_result_hi !== ehi) begin tests_failed++; $display("[TB] FAIL directed_hi[%0d] got=%h want=%h", i, data_result_hi, ehi); end
      if (data_exception !== eexc) begin tests_failed++; $display("[TB] FAIL directed_exc[%0d] got=%b want=%b", i, data_exception, eexc); end
    end
  endtask

  task automatic test_random();
    logic [31:0] corners [5] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h1};
    logic [31:0] a, b, ehi, elo;
    logic        eexc;
    int          cyc;
    bit          seen;
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      model_mult(a, b, 1'b0, ehi, elo, eexc);
      start_and_wait(a, b, 1'b0, cyc, seen);
      tests_run += 2;
      if (!seen || cyc != LAT_S) begin tests_failed++; $display("[TB] FAIL random_latency a=%h b=%h got=%0d want=%0d", a, b, cyc, LAT_S); end
      if ({data_result_hi, data_result, data_exception} !== {ehi, elo, eexc}) begin
        tests_failed++;
        $display("[TB] FAIL random_product a=%h b=%h got=%h_%h/%b want=%h_%h/%b",
                 a, b, data_result_hi, data_result, data_exception, ehi, elo, eexc);
      end
    end
  endtask

  task automatic test_pulse_and_hold();
    logic [31:0] ehi, elo;
    logic        eexc;
    int          cyc;
    bit          seen;
    int          bad;
    model_mult(32'h1234_5678, 32'hFEDC_BA98, 1'b0, ehi, elo, eexc);
    start_and_wait(32'h1234_5678, 32'hFEDC_BA98, 1'b0, cyc, seen);
    bad = 0;
    repeat (4) begin
      @(negedge clock);
      if (data_resultRDY !== 1'b0 || busy !== 1'b0 || data_result !== elo || data_result_hi !== ehi) bad++;
    end
    tests_run += 2;
    if (!seen) begin tests_failed++; $display("[TB] FAIL hold_seen got=0 want=1"); end
    if (bad != 0) begin tests_failed++; $display("[TB] FAIL hold_after_rdy bad_cycles=%0d want=0", bad); end
  endtask

  task automatic test_busy();
    int busy_cycles;
    int cyc;
    @(negedge clock);
    data_operandA = $urandom;
    data_operandB = $urandom;
    ctrl_MULT = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    busy_cycles = 0;
    cyc = 0;
    while (!data_resultRDY && cyc < 60) begin
      if (busy) busy_cycles++;
      @(negedge clock);
      cyc++;
    end
    tests_run += 2;
    if (busy_cycles != LAT_S) begin tests_failed++; $display("[TB] FAIL busy_cycles got=%0d want=%0d", busy_cycles, LAT_S); end
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL busy_on_rdy got=%b want=0", busy); end
  endtask

  task automatic test_restart();
    int early_rdy, extra_rdy, cyc;
    bit seen;
    @(negedge clock);
    data_operandA = $urandom;
    data_operandB = $urandom;
    ctrl_MULT = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    early_rdy = 0;
    repeat (8) begin
      @(negedge clock);
      if (data_resultRDY) early_rdy++;
    end
    data_operandA = 32'd5;
    data_operandB = 32'd6;
    ctrl_MULT = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clock);
      cyc++;
      if (data_resultRDY) seen = 1'b1;
      else if (cyc < LAT_S && data_resultRDY) early_rdy++;
    end
    tests_run += 4;
    if (!seen || cyc != LAT_S) begin tests_failed++; $display("[TB] FAIL restart_latency got=%0d want=%0d", cyc, LAT_S); end
    if (data_result !== 32'd30 || data_result_hi !== 32'd0 || data_exception !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL restart_product got=%h_%h/%b want=00000000_0000001e/0", data_result_hi, data_result, data_exception);
    end
    extra_rdy = 0;
    repeat (20) begin
      @(negedge clock);
      if (data_resultRDY) extra_rdy++;
    end
    if (early_rdy != 0) begin tests_failed++; $display("[TB] FAIL restart_early_rdy got=%0d want=0", early_rdy); end
    if (extra_rdy != 0) begin tests_failed++; $display("[TB] FAIL restart_extra_rdy got=%0d want=0", extra_rdy); end
  endtask

  task automatic test_held_start();
    logic [31:0] a, b, ehi, elo;
    logic        eexc;
    int          held_rdy, cyc;
    bit          seen;
    held_rdy = 0;
    a = '0;
    b = '0;
    @(negedge clock);
    ctrl_MULT = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = $urandom;
      b = $urandom;
      data_operandA = a;
      data_operandB = b;
      @(negedge clock);
      if (data_resultRDY) held_rdy++;
    end
    ctrl_MULT = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    model_mult(a, b, 1'b0, ehi, elo, eexc);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clock);
      cyc++;
      if (data_resultRDY) seen = 1'b1;
    end
    tests_run += 3;
    if (held_rdy != 0) begin tests_failed++; $display("[TB] FAIL held_rdy got=%0d want=0", held_rdy); end
    if (!seen || cyc != LAT_S) begin tests_failed++; $display("[TB] FAIL held_latency got=%0d want=%0d", cyc, LAT_S); end
    if ({data_result_hi, data_result} !== {ehi, elo}) begin
      tests_failed++;
      $display("[TB] FAIL held_product got=%h_%h want=%h_%h", data_result_hi, data_result, ehi, elo);
    end
  endtask

  task automatic test_reset_mid_run();
    int late_rdy;
    int bad_now;
    @(negedge clock);
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h0BAD_CAFE;
    ctrl_MULT = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    #1;
    bad_now = (data_result !== 32'h0 || data_result_hi !== 32'h0 || data_exception !== 1'b0 ||
               data_resultRDY !== 1'b0 || busy !== 1'b0) ? 1 : 0;
    @(negedge clock);
    tests_run += 3;
    if (bad_now != 0) begin tests_failed++; $display("[TB] FAIL midreset_async outputs not cleared"); end
    if ({data_result_hi, data_result, data_exception, data_resultRDY, busy} !== 67'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_outputs got=%h_%h/%b/%b/%b want=all 0",
               data_result_hi, data_result, data_exception, data_resultRDY, busy);
    end
    reset = 1'b0;
    late_rdy = 0;
    repeat (30) begin
      @(negedge clock);
      if (data_resultRDY || busy) late_rdy++;
    end
    if (late_rdy != 0) begin tests_failed++; $display("[TB] FAIL midreset_activity got=%0d want=0", late_rdy); end
  endtask

`ifdef MULT_UNSIGNED_EN
  task automatic test_unsigned();
    logic [31:0] a, b, ehi, elo;
    logic        eexc;
    int          cyc;
    bit          seen;
    for (int i = 0; i < 10; i++) begin
      a = (i == 0) ? 32'hFFFF_FFFF : $urandom;
      b = (i == 0) ? 32'hFFFF_FFFF : $urandom;
      model_mult(a, b, 1'b1, ehi, elo, eexc);
      start_and_wait(a, b, 1'b1, cyc, seen);
      tests_run += 2;
      if (!seen || cyc != LAT_U) begin tests_failed++; $display("[TB] FAIL unsigned_latency got=%0d want=%0d", cyc, LAT_U); end
      if ({data_result_hi, data_result, data_exception} !== {ehi, elo, eexc}) begin
        tests_failed++;
        $display("[TB] FAIL unsigned_product a=%h b=%h got=%h_%h/%b want=%h_%h/%b",
                 a, b, data_result_hi, data_result, data_exception, ehi, elo, eexc);
      end
    end
  endtask
`endif

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_directed();
    test_random();
    test_pulse_and_hold();
    test_busy();
    test_restart();
    test_held_start();
    test_reset_mid_run();
`ifdef MULT_UNSIGNED_EN
    test_unsigned();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
